// File: rtl/parser_input_arbiter.sv
// rtl/parser_input_arbiter.sv - packet-granular round-robin arbiter feeding the sequence parser
// Regenerates dst_last from the header length and flags length mismatches.
module parser_input_arbiter #(
   parameter int N_SRC     = 4,
   parameter int MAX_WORDS = 12,
   localparam int GW       = (N_SRC > 1) ? $clog2(N_SRC) : 1,
   localparam int CW       = $clog2(MAX_WORDS + 1)
) (
   input  logic                 clk,
   input  logic                 reset_b,
   input  logic [32*N_SRC-1:0]  src_data,
   input  logic [N_SRC-1:0]     src_val,
   input  logic [N_SRC-1:0]     src_last,
   output logic [N_SRC-1:0]     src_ready,
   output logic [31:0]          dst_data,
   output logic                 dst_val,
   output logic                 dst_last,
   input  logic                 dst_ready,
   output logic [GW-1:0]        grant_id,
   output logic                 busy,
   output logic                 len_err,
   output logic [GW-1:0]        len_err_src
);

   typedef enum logic [1:0] {IDLE, LOCKED, DRAIN} state_t;

   state_t          state, state_next;
   logic [GW-1:0]   rr_ptr, ptr_next, winner, cand;
   logic [CW-1:0]   word_cnt, exp_words, hdr_clamped;
   logic [16:0]     hdr_words;
   logic [31:0]     words [N_SRC];
   logic            any_val, g_val, g_last, dst_xfer, end_xfer, err_set;

   always_comb begin
      for (int i = 0; i < N_SRC; i++) begin
         words[i] = src_data[32*i +: 32];
      end
      g_val  = src_val[grant_id];
      g_last = src_last[grant_id];
   end

   // First requester at or above rr_ptr, wrapping modulo N_SRC.
   always_comb begin
      winner  = rr_ptr;
      any_val = 1'b0;
      cand    = '0;
      for (int k = 0; k < N_SRC; k++) begin
         cand = GW'((int'(rr_ptr) + k) % N_SRC);
         if (!any_val && src_val[cand]) begin
            winner  = cand;
            any_val = 1'b1;
         end
      end
   end

   // Header length is in bytes; words = ceil(bytes/4), kept within [2, MAX_WORDS].
   always_comb begin
      hdr_words = ({1'b0, dst_data[31:16]} + 17'd3) >> 2;
      if (hdr_words < 17'd2) begin
         hdr_clamped = CW'(2);
      end else if (hdr_words > 17'(MAX_WORDS)) begin
         hdr_clamped = CW'(MAX_WORDS);
      end else begin
         hdr_clamped = hdr_words[CW-1:0];
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = rr_ptr;
      src_ready  = '0;
      dst_data   = words[grant_id];
      dst_val    = 1'b0;
      dst_last   = 1'b0;
      dst_xfer   = 1'b0;
      end_xfer   = 1'b0;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (any_val) state_next = LOCKED;
         end
         LOCKED: begin
            dst_val             = g_val;
            src_ready[grant_id] = dst_ready;
            dst_last            = g_last | ((word_cnt != '0) && (word_cnt == exp_words - 1'b1));
            dst_xfer            = g_val & dst_ready;
            end_xfer            = dst_xfer & dst_last;
            if (end_xfer) begin
               ptr_next = (grant_id == GW'(N_SRC - 1)) ? '0 : grant_id + 1'b1;
               if (g_last) begin
                  state_next = IDLE;
                  err_set    = (word_cnt == '0) || (CW'(word_cnt + 1'b1) < exp_words);
               end else begin
                  state_next = DRAIN;
                  err_set    = 1'b1;
               end
            end
         end
         DRAIN: begin
            src_ready[grant_id] = 1'b1;
            if (g_val && g_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      busy = (state != IDLE);
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         word_cnt    <= '0;
         exp_words   <= CW'(2);
         len_err     <= 1'b0;
         len_err_src <= '0;
      end else begin
         state   <= state_next;
         rr_ptr  <= ptr_next;
         len_err <= err_set;
         if (err_set) len_err_src <= grant_id;
         if (state == IDLE && any_val) begin
            grant_id <= winner;
            word_cnt <= '0;
         end
         if (dst_xfer) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == '0) exp_words <= hdr_clamped;
         end
      end
   end

endmodule

// File: tb/tb_parser_input_arbiter.sv
// tb/tb_parser_input_arbiter.sv - directed self-checking bench for parser_input_arbiter
module tb_parser_input_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset_b = 1'b0;
   logic [127:0]  src_data = '0;
   logic [3:0]    src_val = '0;
   logic [3:0]    src_last = '0;
   logic [3:0]    src_ready;
   logic [31:0]   dst_data;
   logic          dst_val, dst_last;
   logic          dst_ready = 1'b0;
   logic [1:0]    grant_id, len_err_src;
   logic          busy, len_err;

   parser_input_arbiter #(.N_SRC(4), .MAX_WORDS(12)) dut (
      .clk(clk), .reset_b(reset_b),
      .src_data(src_data), .src_val(src_val), .src_last(src_last), .src_ready(src_ready),
      .dst_data(dst_data), .dst_val(dst_val), .dst_last(dst_last), .dst_ready(dst_ready),
      .grant_id(grant_id), .busy(busy), .len_err(len_err), .len_err_src(len_err_src)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        rdy = 1'b1;
   logic [31:0] sq [N][$];
   bit          sl [N][$];
   logic [3:0]  hs = '0;
   logic [31:0] log_d [$];
   bit          log_l [$];
   int          log_c [$];
   logic [1:0]  log_g [$];
   bit          log_b [$];
   int          err_seen = 0;
   int          err_cyc = 0;
   logic [1:0]  err_src = '0;

   function automatic logic [31:0] pw(input int s, input int k, input logic [31:0] hdr);
      if (k == 0) return hdr;
      return 32'hD000_0000 + 32'(s * 256 + k);
   endfunction

   task automatic load_pkt(input int s, input logic [31:0] hdr, input int n);
      for (int k = 0; k < n; k++) begin
         sq[s].push_back(pw(s, k, hdr));
         sl[s].push_back(k == n - 1);
      end
   endtask

   task automatic drive_inputs();
      for (int s = 0; s < N; s++) begin
         if (sq[s].size() > 0) begin
            src_val[s] = 1'b1;
            src_data[32*s +: 32] = sq[s][0];
            src_last[s] = sl[s][0];
         end else begin
            src_val[s] = 1'b0;
            src_data[32*s +: 32] = '0;
            src_last[s] = 1'b0;
         end
      end
      dst_ready = rdy;
   endtask

   task automatic clear_all();
      for (int s = 0; s < N; s++) begin
         sq[s].delete();
         sl[s].delete();
      end
      hs = '0;
      log_d.delete(); log_l.delete(); log_c.delete(); log_g.delete(); log_b.delete();
      err_seen = 0;
      err_cyc = 0;
      err_src = '0;
   endtask

   // One cycle: retire last cycle's source handshakes, drive, then record outputs.
   task automatic step();
      @(negedge clk);
      cyc++;
      for (int s = 0; s < N; s++) begin
         if (hs[s] && sq[s].size() > 0) begin
            void'(sq[s].pop_front());
            void'(sl[s].pop_front());
         end
      end
      drive_inputs();
      #1;
      hs = src_val & src_ready;
      if (dst_val && dst_ready) begin
         log_d.push_back(dst_data);
         log_l.push_back(dst_last);
         log_c.push_back(cyc);
         log_g.push_back(grant_id);
         log_b.push_back(busy);
      end
      if (len_err) begin
         err_seen++;
         err_cyc = cyc;
         err_src = len_err_src;
      end
   endtask

   task automatic do_reset();
      reset_b = 1'b0;
      clear_all();
      rdy = 1'b1;
      drive_inputs();
      repeat (2) @(negedge clk);
      reset_b = 1'b1;
   endtask

   task automatic test_reset();
      reset_b = 1'b0;
      clear_all();
      load_pkt(1, 32'h0010_0001, 4);
      rdy = 1'b1;
      drive_inputs();
      repeat (3) begin
         @(negedge clk);
         #1;
         checks++;
         if ({src_ready, dst_val, dst_last, busy, len_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b val=%b last=%b busy=%b err=%b want all 0",
                     src_ready, dst_val, dst_last, busy, len_err);
         end
         checks++;
         if ({grant_id, len_err_src} !== 4'h0) begin
            errors++;
            $display("FAIL reset_ids: got grant=%0d err_src=%0d want 0 0", grant_id, len_err_src);
         end
      end
      clear_all();
      drive_inputs();
      @(negedge clk);
      reset_b = 1'b1;
   endtask

   task automatic test_single();
      int c0;
      do_reset();
      load_pkt(0, 32'h0010_0003, 4);
      c0 = cyc;
      repeat (8) step();
      checks++;
      if (log_d.size() !== 4) begin
         errors++;
         $display("FAIL single_count: got %0d words want 4", log_d.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (log_d[k] !== pw(0, k, 32'h0010_0003) || log_l[k] !== (k == 3) ||
                log_g[k] !== 2'd0 || log_b[k] !== 1'b1) begin
               errors++;
               $display("FAIL single_word%0d: got %h last=%b g=%0d busy=%b want %h last=%b g=0 busy=1",
                        k, log_d[k], log_l[k], log_g[k], log_b[k], pw(0, k, 32'h0010_0003), (k == 3));
            end
         end
         checks++;
         if (log_c[0] !== c0 + 2 || log_c[3] !== c0 + 5) begin
            errors++;
            $display("FAIL single_timing: got cycles %0d..%0d want %0d..%0d",
                     log_c[0] - c0, log_c[3] - c0, 2, 5);
         end
      end
      checks++;
      if (err_seen !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_end: got errs=%0d busy=%b want 0 0", err_seen, busy);
      end
   endtask

   task automatic test_round_robin();
      int c0;
      logic [31:0] h;
      do_reset();
      for (int s = 0; s < 4; s++) load_pkt(s, 32'h0008_0000 | 32'(s * 16), 2);
      load_pkt(0, 32'h0008_0004, 2);
      c0 = cyc;
      repeat (16) step();
      checks++;
      if (log_d.size() !== 10) begin
         errors++;
         $display("FAIL rr_count: got %0d words want 10", log_d.size());
      end else begin
         for (int p = 0; p < 5; p++) begin
            h = (p < 4) ? (32'h0008_0000 | 32'(p * 16)) : 32'h0008_0004;
            checks++;
            if (log_g[2*p] !== 2'(p % 4) || log_d[2*p] !== h || log_l[2*p] !== 1'b0 ||
                log_c[2*p] !== c0 + 3*p + 2) begin
               errors++;
               $display("FAIL rr_hdr%0d: got g=%0d d=%h last=%b cyc=%0d want g=%0d d=%h last=0 cyc=%0d",
                        p, log_g[2*p], log_d[2*p], log_l[2*p], log_c[2*p] - c0, p % 4, h, 3*p + 2);
            end
            checks++;
            if (log_g[2*p+1] !== 2'(p % 4) || log_d[2*p+1] !== pw(p % 4, 1, h) ||
                log_l[2*p+1] !== 1'b1 || log_c[2*p+1] !== c0 + 3*p + 3) begin
               errors++;
               $display("FAIL rr_tail%0d: got g=%0d d=%h last=%b cyc=%0d want g=%0d d=%h last=1 cyc=%0d",
                        p, log_g[2*p+1], log_d[2*p+1], log_l[2*p+1], log_c[2*p+1] - c0,
                        p % 4, pw(p % 4, 1, h), 3*p + 3);
            end
         end
      end
      checks++;
      if (err_seen !== 0) begin
         errors++;
         $display("FAIL rr_err: got %0d pulses want 0", err_seen);
      end
   endtask

   task automatic test_backpressure();
      int busy_cnt;
      logic [3:0] want;
      busy_cnt = 0;
      do_reset();
      load_pkt(2, 32'h0010_0022, 4);
      rdy = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
         rdy = (i % 2 == 0);
         step();
         if (busy) begin
            busy_cnt++;
            want = rdy ? 4'b0100 : 4'b0000;
            checks++;
            if (src_ready !== want || dst_val !== 1'b1) begin
               errors++;
               $display("FAIL bp_ready%0d: got rdy=%b val=%b want rdy=%b val=1", i, src_ready, dst_val, want);
            end
         end
      end
      checks++;
      if (busy_cnt !== 7) begin
         errors++;
         $display("FAIL bp_busy: got %0d busy cycles want 7", busy_cnt);
      end
      checks++;
      if (log_d.size() !== 4) begin
         errors++;
         $display("FAIL bp_count: got %0d words want 4", log_d.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (log_d[k] !== pw(2, k, 32'h0010_0022) || log_l[k] !== (k == 3)) begin
               errors++;
               $display("FAIL bp_word%0d: got %h last=%b want %h last=%b",
                        k, log_d[k], log_l[k], pw(2, k, 32'h0010_0022), (k == 3));
            end
         end
      end
      checks++;
      if (err_seen !== 0) begin
         errors++;
         $display("FAIL bp_err: got %0d pulses want 0", err_seen);
      end
   endtask

   task automatic test_long();
      int c0, drain_cnt;
      drain_cnt = 0;
      do_reset();
      load_pkt(1, 32'h0040_0011, 16);
      c0 = cyc;
      repeat (20) begin
         step();
         if (busy && !dst_val) begin
            drain_cnt++;
            checks++;
            if (src_ready !== 4'b0010) begin
               errors++;
               $display("FAIL long_drain_ready: got %b want 0010", src_ready);
            end
         end
      end
      checks++;
      if (log_d.size() !== 12) begin
         errors++;
         $display("FAIL long_count: got %0d words want 12", log_d.size());
      end else begin
         for (int k = 0; k < 12; k++) begin
            checks++;
            if (log_d[k] !== pw(1, k, 32'h0040_0011) || log_l[k] !== (k == 11)) begin
               errors++;
               $display("FAIL long_word%0d: got %h last=%b want %h last=%b",
                        k, log_d[k], log_l[k], pw(1, k, 32'h0040_0011), (k == 11));
            end
         end
         checks++;
         if (log_c[11] !== c0 + 13 || err_cyc !== c0 + 14) begin
            errors++;
            $display("FAIL long_timing: got last@%0d err@%0d want last@13 err@14",
                     log_c[11] - c0, err_cyc - c0);
         end
      end
      checks++;
      if (err_seen !== 1 || err_src !== 2'd1) begin
         errors++;
         $display("FAIL long_err: got pulses=%0d src=%0d want 1 1", err_seen, err_src);
      end
      checks++;
      if (drain_cnt !== 4 || busy !== 1'b0 || sq[1].size() !== 0) begin
         errors++;
         $display("FAIL long_drain: got drained=%0d busy=%b left=%0d want 4 0 0",
                  drain_cnt, busy, sq[1].size());
      end
   endtask

   task automatic test_early_end();
      int c0;
      do_reset();
      load_pkt(2, 32'h0018_0032, 3);
      c0 = cyc;
      step();
      step();
      load_pkt(3, 32'h0008_0033, 2);
      load_pkt(0, 32'h0008_0030, 2);
      repeat (12) step();
      checks++;
      if (log_d.size() !== 7) begin
         errors++;
         $display("FAIL early_count: got %0d words want 7", log_d.size());
      end else begin
         checks++;
         if (log_l[2] !== 1'b1 || log_l[1] !== 1'b0 || log_d[2] !== pw(2, 2, 32'h0018_0032) ||
             log_c[2] !== c0 + 4) begin
            errors++;
            $display("FAIL early_last: got d=%h last=%b cyc=%0d want d=%h last=1 cyc=4",
                     log_d[2], log_l[2], log_c[2] - c0, pw(2, 2, 32'h0018_0032));
         end
         checks++;
         if (log_g[3] !== 2'd3 || log_d[3] !== 32'h0008_0033 || log_c[3] !== c0 + 6) begin
            errors++;
            $display("FAIL early_next: got g=%0d d=%h cyc=%0d want g=3 d=00080033 cyc=6",
                     log_g[3], log_d[3], log_c[3] - c0);
         end
         checks++;
         if (log_g[5] !== 2'd0 || log_d[5] !== 32'h0008_0030) begin
            errors++;
            $display("FAIL early_third: got g=%0d d=%h want g=0 d=00080030", log_g[5], log_d[5]);
         end
      end
      checks++;
      if (err_seen !== 1 || err_src !== 2'd2 || err_cyc !== c0 + 5) begin
         errors++;
         $display("FAIL early_err: got pulses=%0d src=%0d cyc=%0d want 1 2 5",
                  err_seen, err_src, err_cyc - c0);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      load_pkt(3, 32'h0010_0043, 4);
      repeat (3) step();
      checks++;
      if (dst_val !== 1'b1 || busy !== 1'b1 || src_ready !== 4'b1000) begin
         errors++;
         $display("FAIL areset_pre: got val=%b busy=%b rdy=%b want 1 1 1000", dst_val, busy, src_ready);
      end
      #2;
      reset_b = 1'b0;
      #1;
      checks++;
      if (dst_val !== 1'b0 || busy !== 1'b0 || src_ready !== 4'b0000) begin
         errors++;
         $display("FAIL areset_now: got val=%b busy=%b rdy=%b want 0 0 0000", dst_val, busy, src_ready);
      end
      clear_all();
      load_pkt(0, 32'h0008_0040, 2);
      drive_inputs();
      @(negedge clk);
      reset_b = 1'b1;
      repeat (6) step();
      checks++;
      if (log_d.size() !== 2) begin
         errors++;
         $display("FAIL areset_count: got %0d words want 2", log_d.size());
      end else begin
         checks++;
         if (log_g[0] !== 2'd0 || log_d[0] !== 32'h0008_0040 || log_l[1] !== 1'b1) begin
            errors++;
            $display("FAIL areset_grant: got g=%0d d=%h last=%b want g=0 d=00080040 last=1",
                     log_g[0], log_d[0], log_l[1]);
         end
      end
      checks++;
      if (err_seen !== 0 || len_err_src !== 2'd0) begin
         errors++;
         $display("FAIL areset_err: got pulses=%0d src=%0d want 0 0", err_seen, len_err_src);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_long();
      test_early_end();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
